// File: rtl/fetch_ctrl.sv
// Fetch control: instruction register, control-op decode, squash and halt.
// Optional FETCH_RETIRE_CNT_EN adds a saturating retired-instruction counter.
module fetch_ctrl #(
  parameter int AddrSz  = 6,
  parameter int InstrSz = 24
`ifdef FETCH_RETIRE_CNT_EN
  ,
  parameter int CntSz   = 16
`endif
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [InstrSz-1:0] instr,
  input  logic               z_flag,
  input  logic               resume,
  output logic [InstrSz-1:0] instr_q,
  output logic               instr_valid,
  output logic               rel_branch,
  output logic [AddrSz-1:0]  offset,
  output logic               halt
`ifdef FETCH_RETIRE_CNT_EN
  ,
  output logic [CntSz-1:0]   retired
`endif
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [2:0] OpBeq  = 3'b100;
  localparam logic [2:0] OpBne  = 3'b101;
  localparam logic [2:0] OpBra  = 3'b110;
  localparam logic [2:0] OpHalt = 3'b111;

  state_t     state;
  logic [2:0] opcode;
  logic       run;
  logic       taken;
  logic       halt_op;

  assign opcode = instr_q[InstrSz-1 -: 3];
  assign run    = (state == RUN);

  always_comb begin
    taken = 1'b0;
    unique case (opcode)
      OpBeq:   taken = z_flag;
      OpBne:   taken = !z_flag;
      OpBra:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign halt_op     = (opcode == OpHalt);
  assign instr_valid = run;
  assign rel_branch  = run && taken;
  assign offset      = rel_branch ? instr_q[AddrSz-1:0] : '0;
  // Resume releases the pc in the same cycle it is seen.
  assign halt        = (run && halt_op) ||
                       ((state == HALTED) && !resume);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= FILL;
      instr_q <= '0;
    end else begin
      instr_q <= instr;
      unique case (state)
        FILL: state <= RUN;
        RUN: begin
          if (taken)        state <= FILL;
          else if (halt_op) state <= HALTED;
        end
        HALTED: if (resume) state <= RUN;
        default: state <= FILL;
      endcase
    end
  end

`ifdef FETCH_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      retired <= '0;
    end else if (instr_valid && (retired != '1)) begin
      retired <= retired + CntSz'(1);
    end
  end
`endif

endmodule
